// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU core.
// Instruction field positions, jump codes and core states.
package hack_pkg;

    localparam int BIT_CI = 15;
    localparam int BIT_A  = 12;
    localparam int C_HI   = 11;
    localparam int C_LO   = 6;
    localparam int D_HI   = 5;
    localparam int D_LO   = 3;
    localparam int J_HI   = 2;
    localparam int J_LO   = 0;

    localparam int DST_A = 2;
    localparam int DST_D = 1;
    localparam int DST_M = 0;

    localparam int J_LT = 2;
    localparam int J_EQ = 1;
    localparam int J_GT = 0;

    localparam logic [2:0] JMP_ALWAYS = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_PAUSE,
        ST_HALT
    } state_e;

    function automatic logic jump_taken(
        input logic [2:0] j,
        input logic       zr,
        input logic       ng
    );
        return (j[J_LT] & ng) | (j[J_EQ] & zr) |
               (j[J_GT] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_alu.sv
// Hack ALU: zx/nx/zy/ny/f/no on 16-bit operands.
// Purely combinational; zr/ng flag the result.
module hack_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [5:0]  c,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x1, x2, y1, y2, f;

    // operand conditioning, function select, output negate
    always_comb begin
        x1  = c[5] ? 16'h0000 : x;
        x2  = c[4] ? ~x1 : x1;
        y1  = c[3] ? 16'h0000 : y;
        y2  = c[2] ? ~y1 : y1;
        f   = c[1] ? (x2 + y2) : (x2 & y2);
        out = c[0] ? ~f : f;
        zr  = (out == 16'h0000);
        ng  = out[15];
    end

endmodule

// File: rtl/hack_core.sv
// Hack CPU core with stalling data port, pause and halt.
// One instruction per cycle unless the data port stalls.
module hack_core
    import hack_pkg::*;
#(
    parameter int PC_W   = 15,
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic [PC_W-1:0]   i_addr,
    input  logic [15:0]       i_data,
    output logic [ADDR_W-1:0] d_addr,
    output logic [15:0]       d_wdata,
    output logic              d_req,
    output logic              d_we,
    input  logic [15:0]       d_rdata,
    input  logic              d_ready,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;

    logic             is_c, is_mem, exec, retire;
    logic             take, halt_hit;
    logic [5:0]       comp;
    logic [2:0]       dst, jmp;
    logic [15:0]      alu_y, alu_out;
    logic             alu_zr, alu_ng;
    logic [PC_W-1:0]  pc_next;

    // instruction decode and issue qualification
    always_comb begin
        is_c     = i_data[BIT_CI];
        comp     = i_data[C_HI:C_LO];
        dst      = i_data[D_HI:D_LO];
        jmp      = i_data[J_HI:J_LO];
        is_mem   = is_c & (i_data[BIT_A] | dst[DST_M]);
        alu_y    = i_data[BIT_A] ? d_rdata : a_q;
        exec     = ((state_q == ST_RUN) & run) |
                   (state_q == ST_WAIT);
        retire   = exec & (~is_mem | d_ready);
        take     = is_c & jump_taken(jmp, alu_zr, alu_ng);
        pc_next  = take ? a_q[PC_W-1:0] : pc_q + PC_W'(1);
        halt_hit = is_c & (jmp == JMP_ALWAYS) &
                   (a_q[PC_W-1:0] == pc_q);
    end

    hack_alu u_alu (
        .x   (d_q),
        .y   (alu_y),
        .c   (comp),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    // data port is driven straight from the pre-update A register
    always_comb begin
        d_req   = exec & is_mem & ~reset;
        d_we    = d_req & dst[DST_M];
        d_addr  = a_q[ADDR_W-1:0];
        d_wdata = alu_out;
        i_addr  = pc_q;
        halted  = halted_q;
        retired = cnt_q;
    end

    // architectural commit and run/wait/pause/halt sequencing
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        if (retire) begin
            pc_d  = pc_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (!is_c) begin
                a_d = {1'b0, i_data[14:0]};
            end else begin
                if (dst[DST_A]) a_d = alu_out;
                if (dst[DST_D]) d_d = alu_out;
            end
        end
        unique case (state_q)
            ST_RUN: begin
                if (!run)          state_d = ST_PAUSE;
                else if (!retire)  state_d = ST_WAIT;
                else if (halt_hit) state_d = ST_HALT;
            end
            ST_WAIT: begin
                if (retire)
                    state_d = halt_hit ? ST_HALT : ST_RUN;
            end
            ST_PAUSE: begin
                if (run) state_d = ST_RUN;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
        halted_d = (state_d == ST_HALT);
    end

    // state registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= '0;
            a_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

endmodule

// File: tb/tb_hack_core.sv
// Scoreboard bench for hack_core: directed programs,
// data-port transfers checked by a separate monitor.
module tb_hack_core;

    typedef struct packed {
        logic        we;
        logic [14:0] addr;
        logic [15:0] wdata;
    } xfer_t;

    localparam logic [5:0] C_ZERO = 6'b101010;
    localparam logic [5:0] C_NEG1 = 6'b111010;
    localparam logic [5:0] C_D    = 6'b001100;
    localparam logic [5:0] C_A    = 6'b110000;
    localparam logic [5:0] C_DPA  = 6'b000010;
    localparam logic [5:0] C_DP1  = 6'b011111;
    localparam logic [5:0] C_AP1  = 6'b110111;
    localparam logic [2:0] DN  = 3'b000;
    localparam logic [2:0] DM  = 3'b001;
    localparam logic [2:0] DD  = 3'b010;
    localparam logic [2:0] DAM = 3'b101;
    localparam logic [2:0] JN  = 3'b000;
    localparam logic [2:0] JLT = 3'b100;
    localparam logic [2:0] JMP = 3'b111;

    logic        clock = 1'b0;
    logic        reset, run, d_ready;
    logic [14:0] i_addr, d_addr;
    logic [15:0] i_data, d_wdata, d_rdata;
    logic        d_req, d_we, halted;
    logic [31:0] retired;

    logic [15:0] rom  [0:32767];
    logic [15:0] dmem [0:32767];
    xfer_t       exp_q[$];
    int          total = 0;
    int          passed = 0;

    assign i_data  = rom[i_addr];
    assign d_rdata = dmem[d_addr];

    always #5 clock = ~clock;

    hack_core dut (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .i_addr  (i_addr),
        .i_data  (i_data),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .halted  (halted),
        .retired (retired)
    );

    function automatic logic [15:0] ai(input int v);
        return {1'b0, v[14:0]};
    endfunction

    function automatic logic [15:0] ci(
        input logic a, input logic [5:0] c,
        input logic [2:0] d, input logic [2:0] j);
        return {3'b111, a, c, d, j};
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h",
                      name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input logic we, input int a,
                        input logic [15:0] w);
        xfer_t x;
        x.we = we;
        x.addr = a[14:0];
        x.wdata = w;
        exp_q.push_back(x);
    endtask

    task automatic begin_test();
        reset = 1'b1;
        run = 1'b1;
        d_ready = 1'b1;
        for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
    endtask

    task automatic release_reset();
        @(negedge clock);
        chk("rst_pc", 32'(i_addr), 0);
        chk("rst_retired", retired, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_dreq", 32'(d_req), 0);
        chk("rst_dwe", 32'(d_we), 0);
        reset = 1'b0;
    endtask

    task automatic wait_halt(input int max);
        int n = 0;
        while (!halted && n < max) begin
            cyc(1);
            n++;
        end
        chk("halt_reached", 32'(halted), 1);
    endtask

    task automatic load_basic();
        rom[0] = ai(2);
        rom[1] = ci(0, C_A, DD, JN);
        rom[2] = ai(3);
        rom[3] = ci(0, C_DPA, DD, JN);
        rom[4] = ai(0);
        rom[5] = ci(0, C_D, DM, JN);
        rom[6] = ai(7);
        rom[7] = ci(0, C_ZERO, DN, JMP);
    endtask

    // monitor: every completing data access must match the queue head
    initial begin
        xfer_t e;
        forever begin
            @(negedge clock);
            #1;
            if (d_req && d_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL xfer_unexpected: got we=%0b addr=%0h data=%0h expected none",
                             d_we, d_addr, d_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_we", 32'(d_we), 32'(e.we));
                    chk("xfer_addr", 32'(d_addr), 32'(e.addr));
                    chk("xfer_wdata", 32'(d_wdata), 32'(e.wdata));
                    if (d_we) dmem[d_addr] = d_wdata;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32768; i++) dmem[i] = 16'h0000;
        reset = 1'b1;
        run = 1'b1;
        d_ready = 1'b1;

        // basic program, ready memory
        begin_test();
        load_basic();
        release_reset();
        push(1'b1, 0, 16'd5);
        cyc(5);
        chk("t1_pc5", 32'(i_addr), 5);
        chk("t1_dreq", 32'(d_req), 1);
        chk("t1_dwe", 32'(d_we), 1);
        chk("t1_daddr", 32'(d_addr), 0);
        chk("t1_wdata", 32'(d_wdata), 5);
        cyc(1);
        chk("t1_retired6", retired, 6);
        cyc(2);
        chk("t1_halted", 32'(halted), 1);
        chk("t1_pc_end", 32'(i_addr), 7);
        chk("t1_ret_end", retired, 8);

        // stalled write
        begin_test();
        load_basic();
        release_reset();
        push(1'b1, 0, 16'd5);
        cyc(4);
        d_ready = 1'b0;
        cyc(1);
        for (int k = 0; k < 3; k++) begin
            chk("t2_pc_hold", 32'(i_addr), 5);
            chk("t2_ret_hold", retired, 5);
            chk("t2_dreq_hold", 32'(d_req), 1);
            chk("t2_dwe_hold", 32'(d_we), 1);
            chk("t2_daddr_hold", 32'(d_addr), 0);
            cyc(1);
        end
        d_ready = 1'b1;
        chk("t2_pc_4th", 32'(i_addr), 5);
        chk("t2_ret_4th", retired, 5);
        cyc(1);
        chk("t2_retired6", retired, 6);
        chk("t2_pc6", 32'(i_addr), 6);

        // conditional jumps and PC wrap
        begin_test();
        rom[0] = ci(0, C_NEG1, DD, JN);
        rom[1] = ai(10);
        rom[2] = ci(0, C_D, DN, JLT);
        rom[10] = ci(0, C_ZERO, DD, JN);
        rom[11] = ai(20);
        rom[12] = ci(0, C_D, DN, JLT);
        rom[13] = ai(32766);
        rom[14] = ci(0, C_ZERO, DN, JMP);
        rom[32766] = ai(0);
        rom[32767] = ci(0, C_ZERO, DN, JMP);
        release_reset();
        cyc(3);
        chk("t3_jlt_taken", 32'(i_addr), 10);
        cyc(3);
        chk("t3_jlt_not", 32'(i_addr), 13);
        cyc(2);
        chk("t3_jmp_far", 32'(i_addr), 32766);
        cyc(2);
        chk("t3_wrap", 32'(i_addr), 0);
        chk("t3_ret", retired, 10);
        chk("t3_noreq", 32'(d_req), 0);

        // halt
        begin_test();
        rom[0] = ai(1);
        rom[1] = ci(0, C_A, DD, JN);
        rom[2] = ai(4);
        rom[3] = ci(0, C_DPA, DD, JN);
        rom[4] = ai(8);
        rom[5] = ai(6);
        rom[6] = ci(0, C_ZERO, DN, JMP);
        release_reset();
        cyc(6);
        chk("t4_not_yet", 32'(halted), 0);
        cyc(1);
        chk("t4_halted", 32'(halted), 1);
        chk("t4_pc", 32'(i_addr), 6);
        chk("t4_ret", retired, 7);
        cyc(3);
        chk("t4_ret_frozen", retired, 7);
        chk("t4_pc_frozen", 32'(i_addr), 6);
        chk("t4_dreq", 32'(d_req), 0);

        // reset while waiting on the data port
        begin_test();
        load_basic();
        release_reset();
        cyc(4);
        d_ready = 1'b0;
        cyc(2);
        chk("t5_in_wait", 32'(i_addr), 5);
        reset = 1'b1;
        d_ready = 1'b1;
        #1;
        chk("t5_rst_dreq", 32'(d_req), 0);
        chk("t5_rst_dwe", 32'(d_we), 0);
        cyc(1);
        chk("t5_pc0", 32'(i_addr), 0);
        chk("t5_ret0", retired, 0);
        chk("t5_a0", 32'(d_addr), 0);
        chk("t5_halted0", 32'(halted), 0);
        reset = 1'b0;
        push(1'b1, 0, 16'd5);
        cyc(6);
        chk("t5_rerun", retired, 6);

        // pause and resume
        begin_test();
        load_basic();
        release_reset();
        push(1'b1, 0, 16'd5);
        cyc(2);
        run = 1'b0;
        cyc(1);
        chk("t6_pause_pc", 32'(i_addr), 2);
        chk("t6_pause_ret", retired, 2);
        chk("t6_pause_req", 32'(d_req), 0);
        cyc(2);
        chk("t6_still_pc", 32'(i_addr), 2);
        chk("t6_still_ret", retired, 2);
        run = 1'b1;
        wait_halt(30);
        chk("t6_final_pc", 32'(i_addr), 7);
        chk("t6_final_ret", retired, 8);

        // memory read, AM destination, then write from D
        begin_test();
        dmem[0] = 16'd5;
        rom[0] = ai(0);
        rom[1] = ci(1, C_AP1, DD, JN);
        rom[2] = ai(9);
        rom[3] = ci(0, C_DP1, DAM, JN);
        rom[4] = ci(0, C_A, DD, JN);
        rom[5] = ai(20);
        rom[6] = ci(0, C_D, DM, JN);
        rom[7] = ai(8);
        rom[8] = ci(0, C_ZERO, DN, JMP);
        push(1'b0, 0, 16'd6);
        push(1'b1, 9, 16'd7);
        push(1'b1, 20, 16'd7);
        release_reset();
        wait_halt(30);
        chk("t7_pc", 32'(i_addr), 8);
        chk("t7_ret", retired, 9);

        cyc(2);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
